// File: rtl/nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack.sv
// nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack: pops reorder contexts and frames/drains returned DMA beats (optional perf counter under NVDLA_SDP_NRDMA_EG_RO_PERF_EN)
module nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack #(
  parameter int DW    = 64,
  parameter int CNT_W = 2
) (
  input  logic          nvdla_core_clk_mgated,
  input  logic          nvdla_core_rstn,
  input  logic          op_en,
  input  logic          roc_rd_pvld,
  output logic          roc_rd_prdy,
  input  logic [3:0]    roc_rd_pd,
  input  logic          dat_in_pvld,
  output logic          dat_in_prdy,
  input  logic [DW-1:0] dat_in_pd,
  output logic          dat_out_pvld,
  input  logic          dat_out_prdy,
  output logic [DW-1:0] dat_out_pd,
  output logic          dat_out_last,
  output logic          dat_out_eos,
  output logic          ctx_idle
`ifdef NVDLA_SDP_NRDMA_EG_RO_PERF_EN
  ,output logic [31:0]  perf_stall_cnt
`endif
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state;
  logic [CNT_W-1:0] beat_cnt;
  logic ctx_drop, ctx_eos;
  logic out_free, dat_acc, last_xfer, pop;
  assign out_free    = !dat_out_pvld || dat_out_prdy;
  assign dat_in_prdy = (state == BUSY) && (ctx_drop || out_free);
  assign dat_acc     = dat_in_pvld && dat_in_prdy;
  assign last_xfer   = dat_acc && (beat_cnt == '0);
  assign roc_rd_prdy = op_en && (state == IDLE || last_xfer);
  assign pop         = roc_rd_pvld && roc_rd_prdy;
  assign ctx_idle    = (state == IDLE) && !dat_out_pvld;
  // context FSM, beat counter and the single registered output stage
  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      ctx_drop     <= 1'b0;
      ctx_eos      <= 1'b0;
      dat_out_pvld <= 1'b0;
      dat_out_pd   <= '0;
      dat_out_last <= 1'b0;
      dat_out_eos  <= 1'b0;
    end else begin
      if (pop) begin
        state    <= BUSY;
        beat_cnt <= roc_rd_pd[CNT_W-1:0];
        ctx_eos  <= roc_rd_pd[2];
        ctx_drop <= roc_rd_pd[3];
      end else begin
        if (last_xfer) state <= IDLE;
        if (dat_acc && beat_cnt != '0) beat_cnt <= beat_cnt - CNT_W'(1);
      end
      if (dat_acc && !ctx_drop) begin
        dat_out_pvld <= 1'b1;
        dat_out_pd   <= dat_in_pd;
        dat_out_last <= beat_cnt == '0;
        dat_out_eos  <= (beat_cnt == '0) && ctx_eos;
      end else if (dat_out_prdy) dat_out_pvld <= 1'b0;
    end
`ifdef NVDLA_SDP_NRDMA_EG_RO_PERF_EN
  logic op_en_d;
  // saturating downstream-stall counter, cleared when a new layer is enabled
  always_ff @(posedge nvdla_core_clk_mgated or negedge nvdla_core_rstn)
    if (!nvdla_core_rstn) begin
      op_en_d        <= 1'b0;
      perf_stall_cnt <= '0;
    end else begin
      op_en_d <= op_en;
      if (op_en && !op_en_d) perf_stall_cnt <= '0;
      else if (dat_out_pvld && !dat_out_prdy && perf_stall_cnt != '1) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack.sv
// tb_nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack: scoreboard bench for the reorder context unpacker
module tb_nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack;
  localparam int DW = 64;
  logic clk = 0, rstn = 0, op_en = 0, roc_rd_pvld = 0, dat_in_pvld = 0, dat_out_prdy = 1;
  logic [3:0] roc_rd_pd = '0;
  logic [DW-1:0] dat_in_pd = '0;
  logic roc_rd_prdy, dat_in_prdy, dat_out_pvld, dat_out_last, dat_out_eos, ctx_idle;
  logic [DW-1:0] dat_out_pd;
`ifdef NVDLA_SDP_NRDMA_EG_RO_PERF_EN
  logic [31:0] perf_stall_cnt;
`endif
  nv_nvdla_sdp_nrdma_eg_ro_ctx_unpack #(.DW(DW), .CNT_W(2)) dut (
    .nvdla_core_clk_mgated(clk),
    .nvdla_core_rstn(rstn),
    .op_en(op_en),
    .roc_rd_pvld(roc_rd_pvld),
    .roc_rd_prdy(roc_rd_prdy),
    .roc_rd_pd(roc_rd_pd),
    .dat_in_pvld(dat_in_pvld),
    .dat_in_prdy(dat_in_prdy),
    .dat_in_pd(dat_in_pd),
    .dat_out_pvld(dat_out_pvld),
    .dat_out_prdy(dat_out_prdy),
    .dat_out_pd(dat_out_pd),
    .dat_out_last(dat_out_last),
    .dat_out_eos(dat_out_eos),
    .ctx_idle(ctx_idle)
`ifdef NVDLA_SDP_NRDMA_EG_RO_PERF_EN
    ,.perf_stall_cnt(perf_stall_cnt)
`endif
  );
  always #5 clk = ~clk;

  typedef struct packed {logic [DW-1:0] d; logic l; logic e;} exp_t;
  exp_t sb[$];
  exp_t e_cur;
  int pop_cyc[$], acc_cyc[$], out_cyc[$];
  int checks = 0, errors = 0, cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input logic l, input logic e);
    sb.push_back({d, l, e});
  endtask

  task automatic clear_logs();
    pop_cyc.delete();
    acc_cyc.delete();
    out_cyc.delete();
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // handshake logger and scoreboard monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (roc_rd_pvld && roc_rd_prdy) pop_cyc.push_back(cyc);
    if (dat_in_pvld && dat_in_prdy) acc_cyc.push_back(cyc);
    if (dat_out_pvld && dat_out_prdy) begin
      out_cyc.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got pd %0h, required no output", dat_out_pd);
      end else begin
        e_cur = sb.pop_front();
        chk("out_pd", dat_out_pd, e_cur.d);
        chk("out_last", 64'(dat_out_last), 64'(e_cur.l));
        chk("out_eos", 64'(dat_out_eos), 64'(e_cur.e));
      end
    end
  end

  task automatic send_ctx(input logic [3:0] c);
    int n = 0;
    roc_rd_pvld = 1;
    roc_rd_pd = c;
    @(negedge clk);
    while (!roc_rd_prdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL ctx_pop_timeout: ctx %0h not popped within 200 cycles", c);
    end
    @(posedge clk);
    #1 roc_rd_pvld = 0;
  endtask

  task automatic send_beat(input logic [DW-1:0] d);
    int n = 0;
    dat_in_pvld = 1;
    dat_in_pd = d;
    @(negedge clk);
    while (!dat_in_prdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++;
      errors++;
      $display("FAIL beat_timeout: beat %0h not accepted within 200 cycles", d);
    end
    @(posedge clk);
    #1 dat_in_pvld = 0;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    step(3);
    chk("rst_pvld", 64'(dat_out_pvld), 0);
    chk("rst_pd", dat_out_pd, 0);
    chk("rst_last", 64'(dat_out_last), 0);
    chk("rst_eos", 64'(dat_out_eos), 0);
    chk("rst_idle", 64'(ctx_idle), 1);
    chk("rst_in_prdy", 64'(dat_in_prdy), 0);
    rstn = 1;
    op_en = 1;
    step(1);
    // four-beat context, full throughput
    clear_logs();
    push(64'hA, 0, 0); push(64'hB, 0, 0); push(64'hC, 0, 0); push(64'hD, 1, 0);
    fork
      send_ctx(4'b0011);
      begin send_beat(64'hA); send_beat(64'hB); send_beat(64'hC); send_beat(64'hD); end
    join
    step(2);
    chk("t1_idle", 64'(ctx_idle), 1);
    chk("t1_n_out", 64'(out_cyc.size()), 4);
    chk("t1_n_acc", 64'(acc_cyc.size()), 4);
    for (int i = 0; i < 4 && i < out_cyc.size() && i < acc_cyc.size(); i++)
      chk("t1_latency", 64'(out_cyc[i] - acc_cyc[i]), 1);
    if (acc_cyc.size() == 4) chk("t1_back_to_back", 64'(acc_cyc[3] - acc_cyc[0]), 3);
    // single beat with end-of-surface
    push(64'hE, 1, 1);
    fork
      send_ctx(4'b0100);
      send_beat(64'hE);
    join
    chk("t2_busy_with_out", 64'(ctx_idle), 0);
    step(1);
    chk("t2_idle_after_accept", 64'(ctx_idle), 1);
    // drop context followed by a normal one, popped on the last drained beat
    clear_logs();
    push(64'h2, 1, 0);
    fork
      begin send_ctx(4'b1001); send_ctx(4'b0000); end
      begin send_beat(64'h0); send_beat(64'h1); send_beat(64'h2); end
    join
    step(2);
    chk("t3_n_pop", 64'(pop_cyc.size()), 2);
    chk("t3_n_out", 64'(out_cyc.size()), 1);
    if (pop_cyc.size() == 2 && acc_cyc.size() == 3) chk("t3_pop_with_y", 64'(pop_cyc[1]), 64'(acc_cyc[1]));
    // downstream stall for five cycles
    dat_out_prdy = 0;
    push(64'h50, 0, 0); push(64'h51, 1, 0);
    fork
      send_ctx(4'b0001);
      begin send_beat(64'h50); send_beat(64'h51); end
      begin
        int n = 0;
        do begin step(1); n++; end while (!dat_out_pvld && n < 200);
        for (int i = 0; i < 5; i++) begin
          chk("t4_stall_pd", dat_out_pd, 64'h50);
          chk("t4_stall_in_prdy", 64'(dat_in_prdy), 0);
          step(1);
        end
`ifdef NVDLA_SDP_NRDMA_EG_RO_PERF_EN
        chk("t4_perf_stall", 64'(perf_stall_cnt), 5);
`endif
        dat_out_prdy = 1;
      end
    join
    step(2);
    // op_en low blocks pops and idle data is not accepted
    clear_logs();
    op_en = 0;
    roc_rd_pvld = 1;
    roc_rd_pd = 4'b0000;
    dat_in_pvld = 1;
    dat_in_pd = 64'hDEAD;
    step(3);
    chk("t5_no_prdy", 64'(roc_rd_prdy), 0);
    chk("t5_idle_in_prdy", 64'(dat_in_prdy), 0);
    chk("t5_idle", 64'(ctx_idle), 1);
    chk("t5_no_pop", 64'(pop_cyc.size()), 0);
    roc_rd_pvld = 0;
    dat_in_pvld = 0;
    op_en = 1;
    push(64'h61, 0, 0); push(64'h62, 0, 0); push(64'h63, 1, 0);
    fork
      begin send_ctx(4'b0010); op_en = 0; end
      begin send_beat(64'h61); send_beat(64'h62); send_beat(64'h63); end
    join
    step(2);
    chk("t5_done_idle", 64'(ctx_idle), 1);
    roc_rd_pvld = 1;
    step(2);
    chk("t5_off_prdy", 64'(roc_rd_prdy), 0);
    chk("t5_one_pop", 64'(pop_cyc.size()), 1);
    roc_rd_pvld = 0;
    op_en = 1;
    step(1);
    // reset in the middle of a four-beat context
    push(64'h71, 0, 0); push(64'h72, 0, 0);
    fork
      send_ctx(4'b0011);
      begin send_beat(64'h71); send_beat(64'h72); end
    join
    chk("t6_pending_before_rst", 64'(sb.size()), 1);
    rstn = 0;
    #1;
    chk("t6_rst_pvld", 64'(dat_out_pvld), 0);
    chk("t6_rst_pd", dat_out_pd, 0);
    chk("t6_rst_last", 64'(dat_out_last), 0);
    chk("t6_rst_eos", 64'(dat_out_eos), 0);
    chk("t6_rst_idle", 64'(ctx_idle), 1);
    chk("t6_rst_in_prdy", 64'(dat_in_prdy), 0);
    sb.delete();
    step(2);
    rstn = 1;
    step(1);
    push(64'h80, 1, 0);
    fork
      send_ctx(4'b0000);
      send_beat(64'h80);
    join
    step(3);
    chk("t6_final_idle", 64'(ctx_idle), 1);
    chk("sb_empty", 64'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
